// File: rtl/imm_rot_encoder.sv
// imm_rot_encoder: sequential search for the ARM rotated-immediate
// encoding (imm8, rot4) of a 32-bit constant, one rotation per clock.
module imm_rot_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [7:0]  imm8,
  output logic [3:0]  rot4,
  output logic        carry_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [3:0]  r;
  logic [31:0] value_q;
  logic        carry_q;

  logic [4:0]  sh;
  logic [63:0] dbl;
  logic [31:0] t;
  logic        match;
  logic        last;

  // ROL by 2r via a doubled word, so r=0 needs no special case
  assign sh    = {r, 1'b0};
  assign dbl   = {value_q, value_q} << sh;
  assign t     = dbl[63:32];
  assign match = (t[31:8] == 24'd0);
  assign last  = (r == 4'd15);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SEARCH;
      SEARCH:  if (match || last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      r         <= 4'd0;
      value_q   <= 32'd0;
      carry_q   <= 1'b0;
      valid     <= 1'b0;
      imm8      <= 8'd0;
      rot4      <= 4'd0;
      carry_out <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (start) begin
            value_q <= value;
            carry_q <= carry_in;
            r       <= 4'd0;
          end
        end
        SEARCH: begin
          if (match) begin
            valid     <= 1'b1;
            imm8      <= t[7:0];
            rot4      <= r;
            // zero rotation leaves the shifter carry untouched
            carry_out <= (r == 4'd0) ? carry_q : value_q[31];
          end else if (last) begin
            valid     <= 1'b0;
            imm8      <= 8'd0;
            rot4      <= 4'd0;
            carry_out <= carry_q;
          end else begin
            r <= r + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_rot_encoder.sv
// tb_imm_rot_encoder: directed vectors with hand-computed encodings,
// latency, held-start, and mid-search reset behaviour.
module tb_imm_rot_encoder;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] value;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic        valid;
  logic [7:0]  imm8;
  logic [3:0]  rot4;
  logic        carry_out;

  int total = 0;
  int bad   = 0;
  int dbl   = 0;
  logic prev_done = 1'b0;

  imm_rot_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .value     (value),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .valid     (valid),
    .imm8      (imm8),
    .rot4      (rot4),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done && prev_done) dbl++;
    prev_done = done;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // called at the negedge of cycle 1; returns the cycle done was seen
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic launch(input logic [31:0] v, input logic c);
    @(negedge clk);
    value    = v;
    carry_in = c;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    value    = ~v;
    carry_in = ~c;
  endtask

  typedef struct {
    logic [31:0] v;
    logic        c;
    int          cyc;
    logic        vld;
    logic [7:0]  imm;
    logic [3:0]  rot;
    logic        co;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    int seen;
    vecs[0] = '{32'h0000_00FF, 1'b1,  2, 1'b1, 8'hFF, 4'd0,  1'b1};
    vecs[1] = '{32'hFF00_0000, 1'b0,  6, 1'b1, 8'hFF, 4'd4,  1'b1};
    vecs[2] = '{32'hF000_000F, 1'b0,  4, 1'b1, 8'hFF, 4'd2,  1'b1};
    vecs[3] = '{32'h0000_03FC, 1'b1, 17, 1'b1, 8'hFF, 4'd15, 1'b0};
    vecs[4] = '{32'h0000_0101, 1'b0, 17, 1'b0, 8'h00, 4'd0,  1'b0};
    vecs[5] = '{32'h0000_0000, 1'b1,  2, 1'b1, 8'h00, 4'd0,  1'b1};
    vecs[6] = '{32'h0000_0101, 1'b1, 17, 1'b0, 8'h00, 4'd0,  1'b1};

    reset_n  = 1'b0;
    start    = 1'b0;
    value    = 32'd0;
    carry_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out", {valid, imm8, rot4, carry_out}, 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      launch(vecs[i].v, vecs[i].c);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      wait_done(n);
      chk($sformatf("v%0d_cyc", i), n, vecs[i].cyc);
      chk($sformatf("v%0d_vld", i), {31'd0, valid}, {31'd0, vecs[i].vld});
      chk($sformatf("v%0d_imm", i), {24'd0, imm8}, {24'd0, vecs[i].imm});
      chk($sformatf("v%0d_rot", i), {28'd0, rot4}, {28'd0, vecs[i].rot});
      chk($sformatf("v%0d_co", i), {31'd0, carry_out}, {31'd0, vecs[i].co});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), {30'd0, busy, done}, 32'd0);
    end

    // start held high, inputs changing during the search
    @(negedge clk);
    value    = 32'hFF00_0000;
    carry_in = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    value    = 32'h0000_00FF;
    carry_in = 1'b0;
    wait_done(n);
    chk("hold1_cyc", n, 6);
    chk("hold1_res", {valid, imm8, rot4, carry_out}, {1'b1, 8'hFF, 4'd4, 1'b1});
    @(posedge clk);
    @(negedge clk);
    chk("hold_idle", {30'd0, busy, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("hold2_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("hold2_cyc", n, 2);
    chk("hold2_res", {valid, imm8, rot4, carry_out}, {1'b1, 8'hFF, 4'd0, 1'b0});
    @(posedge clk);

    // reset in cycle 5 of a non-encodable search
    launch(32'h0000_0101, 1'b1);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    chk("mrst_bd", {30'd0, busy, done}, 32'd0);
    chk("mrst_out", {valid, imm8, rot4, carry_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("mrst_nodone", seen, 0);
    launch(32'h0000_0FF0, 1'b1);
    wait_done(n);
    chk("post_cyc", n, 16);
    chk("post_res", {valid, imm8, rot4, carry_out}, {1'b1, 8'hFF, 4'd14, 1'b0});
    @(posedge clk);
    @(negedge clk);
    chk("no_dbl_done", dbl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
